// File: rtl/x68k_ldr_pkg.sv
// Shared types and default sizing for the X68K ioctl loader bridge.
package x68k_ldr_pkg;

    localparam int LDR_AW       = 20;
    localparam int LDR_DEPTH    = 8;
    localparam int LDR_WAIT_LVL = 6;

    typedef enum logic [1:0] {P_IDLE, P_LOAD, P_DRAIN, P_DONE} phase_t;
    typedef enum logic [1:0] {H_IDLE, H_REQ, H_REL} hs_t;

    typedef struct packed {
        logic [LDR_AW-1:0] addr;
        logic [7:0]        data;
    } ldr_entry_t;

endpackage

// File: rtl/x68k_ldr_fifo.sv
// Synchronous FIFO of loader entries; a push on a full FIFO is accepted only when a pop frees a slot that cycle.
module x68k_ldr_fifo
    import x68k_ldr_pkg::*;
#(
    parameter int DEPTH = LDR_DEPTH
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  ldr_entry_t                 din,
    output ldr_entry_t                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ldr_entry_t    mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_sys) begin
        if (do_push)
            mem[wp] <= din;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/x68k_ldr_bridge.sv
// Buffers the hps_io ioctl byte stream and replays it into the X68K loader port via req/ack.
// Optional build macro LDR_CHECKSUM_EN adds the ldr_sum byte checksum output.
module x68k_ldr_bridge
    import x68k_ldr_pkg::*;
#(
    parameter int AW       = LDR_AW,
    parameter int DEPTH    = LDR_DEPTH,
    parameter int WAIT_LVL = LDR_WAIT_LVL
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] ldr_addr,
    output logic [7:0]    ldr_wdat,
    output logic          ldr_aen,
    output logic          ldr_wr,
    input  logic          ldr_ack,
    output logic          ldr_done,
    output logic          ldr_ovf
`ifdef LDR_CHECKSUM_EN
    ,
    output logic [15:0]   ldr_sum
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    phase_t        phase, phase_n;
    hs_t           hs, hs_n;
    logic          dl_q;
    logic          push_req, push_ok, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt, cnt_n;
    ldr_entry_t    wr_ent, head;

    assign wr_ent   = '{addr: LDR_AW'(ioctl_addr), data: ioctl_dout};
    assign push_req = ioctl_wr && (phase == P_LOAD);
    assign pop      = (hs == H_REQ) && ldr_ack;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign cnt_n    = fifo_cnt + CW'(push_ok) - CW'(pop);
    assign ldr_aen  = (phase == P_LOAD) || (phase == P_DRAIN);
    assign ldr_done = (phase == P_DONE);

    x68k_ldr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (pop),
        .din     (wr_ent),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    always_comb begin
        phase_n = phase;
        hs_n    = hs;
        case (phase)
            P_IDLE:  if (ioctl_download && !dl_q)       phase_n = P_LOAD;
            P_LOAD:  if (!ioctl_download)               phase_n = P_DRAIN;
            P_DRAIN: if (fifo_empty && hs == H_IDLE)    phase_n = P_DONE;
            default: phase_n = phase;
        endcase
        // Requiring ack low before a new request keeps a long ack from retiring two bytes.
        case (hs)
            H_IDLE:  if (!fifo_empty && ldr_aen && !ldr_ack) hs_n = H_REQ;
            H_REQ:   if (ldr_ack)                            hs_n = H_REL;
            H_REL:   if (!ldr_ack)                           hs_n = H_IDLE;
            default: hs_n = H_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            phase      <= P_IDLE;
            hs         <= H_IDLE;
            dl_q       <= 1'b0;
            ldr_wr     <= 1'b0;
            ldr_addr   <= '0;
            ldr_wdat   <= '0;
            ldr_ovf    <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            phase      <= phase_n;
            hs         <= hs_n;
            dl_q       <= ioctl_download;
            ldr_wr     <= (hs_n == H_REQ);
            if (hs == H_IDLE && hs_n == H_REQ) begin
                ldr_addr <= AW'(head.addr);
                ldr_wdat <= head.data;
            end
            if (push_req && !push_ok)
                ldr_ovf <= 1'b1;
            ioctl_wait <= (cnt_n >= CW'(WAIT_LVL));
        end
    end

`ifdef LDR_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            ldr_sum <= '0;
        else if (pop && phase != P_DONE)
            ldr_sum <= ldr_sum + {8'h00, head.data};
    end
`else
    // Checksum disabled: no ldr_sum port and no adder.
`endif

endmodule

// File: tb/tb_x68k_ldr_bridge.sv
// Randomized bench for x68k_ldr_bridge against a queue-based reference model of the loader stream.
module tb_x68k_ldr_bridge;

    localparam int DEPTH    = 8;
    localparam int WAIT_LVL = 6;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [19:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [19:0] ldr_addr;
    logic [7:0]  ldr_wdat;
    logic        ldr_aen, ldr_wr, ldr_done, ldr_ovf;
    logic        ldr_ack = 1'b0;
`ifdef LDR_CHECKSUM_EN
    logic [15:0] ldr_sum;
`endif

    x68k_ldr_bridge dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ldr_addr       (ldr_addr),
        .ldr_wdat       (ldr_wdat),
        .ldr_aen        (ldr_aen),
        .ldr_wr         (ldr_wr),
        .ldr_ack        (ldr_ack),
        .ldr_done       (ldr_done),
        .ldr_ovf        (ldr_ovf)
`ifdef LDR_CHECKSUM_EN
        ,
        .ldr_sum        (ldr_sum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Core side: ack ack_lat cycles after seeing a request, hold ack for ack_hold cycles.
    int ack_lat  = 1;
    int ack_hold = 1;
    int core_cnt = 0;
    always @(posedge clk_sys) begin
        #2;
        if (!reset_n) begin
            ldr_ack  = 1'b0;
            core_cnt = 0;
        end else if (!ldr_ack) begin
            if (ldr_wr) begin
                core_cnt++;
                if (core_cnt >= ack_lat) begin ldr_ack = 1'b1; core_cnt = 0; end
            end else core_cnt = 0;
        end else begin
            core_cnt++;
            if (core_cnt >= ack_hold) begin ldr_ack = 1'b0; core_cnt = 0; end
        end
    end

    // Reference model: bytes accepted by the bridge, in order; occupancy = accepted minus retired.
    logic [27:0] exp_q[$];
    int          occ = 0;
    int          mph = 0;   // 0 before download, 1 loading, 2 after download (terminal)
    bit          dlp = 0;
    bit          movf = 0;
    bit          m_valid = 0;
    bit          prev_wr = 0;
    bit          saw_wait = 0;
    int          n_wr = 0;
    int          n_acc = 0;
    logic [15:0] msum = '0;

    always @(negedge clk_sys) begin
        logic [27:0] e;
        bit acc, pop;
        if (m_valid) begin
            if (ldr_wr && !prev_wr) begin
                n_wr++;
                if (exp_q.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", ldr_addr, e[27:8]);
                    chk("wr_data", ldr_wdat, e[7:0]);
                end
            end
            chk("wait", ioctl_wait, occ >= WAIT_LVL);
            chk("ovf", ldr_ovf, movf);
            if (ioctl_wait) saw_wait = 1;
        end
        prev_wr = ldr_wr;
        if (!reset_n) begin
            exp_q.delete();
            occ = 0; mph = 0; dlp = 0; movf = 0; n_wr = 0; n_acc = 0; msum = '0;
            m_valid = 1;
        end else begin
            pop = ldr_wr && ldr_ack;
            acc = ioctl_wr && mph == 1 && (occ < DEPTH || pop);
            if (ioctl_wr && mph == 1 && !acc) movf = 1;
            if (acc) begin
                exp_q.push_back({ioctl_addr, ioctl_dout});
                n_acc++;
                msum = msum + {8'h00, ioctl_dout};
            end
            occ = occ + int'(acc) - int'(pop);
            if (mph == 0 && ioctl_download && !dlp) mph = 1;
            else if (mph == 1 && !ioctl_download) mph = 2;
            dlp = ioctl_download;
        end
    end

    task automatic do_reset();
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        reset_n        = 1'b0;
        @(posedge clk_sys); #1;
        reset_n        = 1'b1;
        saw_wait       = 0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        repeat (2) begin @(posedge clk_sys); #1; end
    endtask

    task automatic send_bytes(input int n, input bit honour, input int max_gap, input bit ff_data);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            repeat ($urandom_range(0, max_gap)) begin ioctl_wr = 1'b0; @(posedge clk_sys); #1; end
            while (honour && ioctl_wait && guard < 500) begin
                ioctl_wr = 1'b0; @(posedge clk_sys); #1; guard++;
            end
            if (guard >= 500) chk("wait_timeout", 1, 0);
            ioctl_wr   = 1'b1;
            ioctl_addr = 20'($urandom);
            ioctl_dout = ff_data ? 8'hFF : 8'($urandom);
            @(posedge clk_sys); #1;
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic finish_dl(input int max_cyc);
        ioctl_download = 1'b0;
        for (int i = 0; i < max_cyc && !ldr_done; i++) begin @(posedge clk_sys); #1; end
        chk("done", ldr_done, 1);
        chk("aen_off", ldr_aen, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("write_count", n_wr, n_acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) begin @(posedge clk_sys); #1; end

        // Test 1: single byte, latency and reset state; a strobe before the download is ignored.
        do_reset();
        chk("rst_wr", ldr_wr, 0);
        chk("rst_aen", ldr_aen, 0);
        chk("rst_done", ldr_done, 0);
        chk("rst_ovf", ldr_ovf, 0);
        chk("rst_wait", ioctl_wait, 0);
`ifdef LDR_CHECKSUM_EN
        chk("rst_sum", ldr_sum, 0);
`endif
        ack_lat = 3; ack_hold = 1;
        ioctl_wr = 1'b1; ioctl_addr = 20'h00077; ioctl_dout = 8'h11;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        start_dl();
        chk("aen_load", ldr_aen, 1);
        ioctl_wr = 1'b1; ioctl_addr = 20'h00010; ioctl_dout = 8'hA5;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        chk("lat_n1", ldr_wr, 0);
        @(posedge clk_sys); #1;
        chk("lat_n2", ldr_wr, 1);
        chk("t1_addr", ldr_addr, 20'h00010);
        chk("t1_data", ldr_wdat, 8'hA5);
        finish_dl(100);
        chk("t1_writes", n_wr, 1);
        chk("t1_ovf", ldr_ovf, 0);

        // Test 2: 16-byte burst, hps honours wait.
        do_reset();
        ack_lat = 5; ack_hold = 1;
        start_dl();
        send_bytes(16, 1, 0, 0);
        finish_dl(500);
        chk("t2_writes", n_wr, 16);
        chk("t2_ovf", ldr_ovf, 0);
        chk("t2_saw_wait", saw_wait, 1);

        // Test 3: same burst ignoring wait; overflowed bytes dropped, ovf sticky.
        do_reset();
        ack_lat = 5; ack_hold = 1;
        start_dl();
        send_bytes(16, 0, 0, 0);
        finish_dl(500);
        chk("t3_ovf", ldr_ovf, 1);

        // Test 4: long ack, one write per byte.
        do_reset();
        ack_lat = 2; ack_hold = 10;
        start_dl();
        send_bytes(6, 1, 0, 0);
        finish_dl(500);
        chk("t4_writes", n_wr, 6);

        // Test 5: reset while a request is outstanding with bytes queued.
        do_reset();
        ack_lat = 1000; ack_hold = 1;
        start_dl();
        send_bytes(5, 1, 0, 0);
        repeat (2) begin @(posedge clk_sys); #1; end
        chk("t5_req", ldr_wr, 1);
        do_reset();
        chk("t5_wr", ldr_wr, 0);
        chk("t5_aen", ldr_aen, 0);
        chk("t5_done", ldr_done, 0);
        chk("t5_wait", ioctl_wait, 0);
        ack_lat = 2;
        start_dl();
        send_bytes(3, 1, 1, 0);
        finish_dl(200);
        chk("t5_writes", n_wr, 3);

        // Randomized traffic: random core latency, gaps and wait handling.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            ack_lat  = $urandom_range(1, 6);
            ack_hold = $urandom_range(1, 4);
            start_dl();
            send_bytes(24, 1'($urandom_range(0, 1)), 2, 0);
            finish_dl(1000);
        end

`ifdef LDR_CHECKSUM_EN
        // Checksum: 300 x 0xFF, then a second download after done is ignored.
        do_reset();
        ack_lat = 1; ack_hold = 1;
        start_dl();
        send_bytes(300, 1, 0, 1);
        finish_dl(5000);
        chk("sum", ldr_sum, 16'h2AD4);
        chk("sum_model", ldr_sum, msum);
        start_dl();
        send_bytes(4, 0, 0, 0);
        ioctl_download = 1'b0;
        repeat (10) begin @(posedge clk_sys); #1; end
        chk("sum_frozen", ldr_sum, 16'h2AD4);
        chk("done_kept", ldr_done, 1);
        chk("aen_after", ldr_aen, 0);
        chk("wait_after", ioctl_wait, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
